pal_cfg_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain of the PAL core. It accepts configuration bytes over a valid/ready handshake and serializes them, one bit per clock, onto the chain's CFG/EN inputs. After exactly SR_LEN shifts it signals completion. It sits between the host-facing byte interface (SPI/UART bridge) and the PAL instance and is the transmitting end of the chain's serial load protocol.

---
 rtl/pal_cfg_loader.sv | 173 +++++++++++++++++
 tb/tb_pal_cfg_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// Serializes configuration bytes onto the PAL serial chain (CFG/EN), one bit per clock, SR_LEN bits per load.
// Latency: byte accepted at cycle a shifts on cycles a+1..a+8; DONE one cycle after the last shift (or checksum accept).
// Backpressure: IN_READY is high only in LOAD/CHECK; a held IN_VALID yields one byte every 9 cycles.
//
// Ports:
//   CLK, RES_N           clock (shared with the PAL chain), asynchronous active-low reset
//   START, ABORT         begin a load (IDLE only) / cancel a load in progress (priority over all else)
//   IN_DATA/IN_VALID/IN_READY  byte handshake from the host bridge
//   CFG_EN, CFG_BIT      chain shift enable and serial data (MSB of each byte first)
//   BUSY, DONE, ERR      load in progress, one-cycle completion pulse, sticky checksum error
//
// Optional feature: define PAL_CFG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte
// (CHECK state); without it ERR is tied low and DONE follows the final shift directly.
// All outputs decode from registered state only, so no input-to-output combinational paths exist.

module pal_cfg_loader #(
   parameter int SR_LEN = 192,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RES_N,
   input  logic              START,
   input  logic              ABORT,
   input  logic [DATA_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic              CFG_EN,
   output logic              CFG_BIT,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam int CNT_W = $clog2(SR_LEN + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      ST_CHECK = 3'd3,
`endif
      ST_FIN   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;       // bits still to be shifted in this load
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_q, bit_d;       // bit position within the current byte
   logic             last_bit;

`ifdef PAL_CFG_LOADER_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;     // XOR of every data byte as received
   logic             err_q, err_d;
`endif

   // The shift in progress is the final one of the whole load.
   assign last_bit = (cnt_q <= CNT_W'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               cnt_d   = CNT_W'(SR_LEN);
               state_d = ST_LOAD;
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
               err_d   = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else if (IN_VALID) begin
               shreg_d = IN_DATA[7:0];
               bit_d   = 3'd0;
               state_d = ST_SHIFT;
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
               // Includes bits of a partial final byte that never reach the chain.
               csum_d  = csum_q ^ IN_DATA[7:0];
`endif
            end
         end
         ST_SHIFT: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else begin
               shreg_d = {shreg_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
               if (last_bit) begin
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_FIN;
`endif
               end else if (bit_q == 3'd7) begin
                  state_d = ST_LOAD;
               end
            end
         end
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else if (IN_VALID) begin
               if (IN_DATA[7:0] != csum_q) begin
                  err_d = 1'b1;
               end
               state_d = ST_FIN;
            end
         end
`endif
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= 8'h00;
         bit_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
      end
   end

`ifdef PAL_CFG_LOADER_CHECKSUM_EN
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         csum_q <= 8'h00;
         err_q  <= 1'b0;
      end else begin
         csum_q <= csum_d;
         err_q  <= err_d;
      end
   end

   assign ERR      = err_q;
   assign IN_READY = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CHECK);
`else
   assign ERR      = 1'b0;
   assign IN_READY = (state_q == ST_LOAD);
   assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
`endif

   assign CFG_EN  = (state_q == ST_SHIFT);
   // Gated so CFG_BIT idles low outside a shift.
   assign CFG_BIT = (state_q == ST_SHIFT) && shreg_q[7];
   assign DONE    = (state_q == ST_FIN);

endmodule

// File: tb/tb_pal_cfg_loader.sv
module tb_pal_cfg_loader;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic            RES_N;
   logic [1:0]      start, abort, in_valid;
   logic [1:0][7:0] in_data;
   logic [1:0]      in_ready, cfg_en, cfg_bit, busy, done, err;

   pal_cfg_loader #(.SR_LEN(12), .DATA_W(8)) u_dut12 (
      .CLK(CLK), .RES_N(RES_N), .START(start[0]), .ABORT(abort[0]),
      .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
      .CFG_EN(cfg_en[0]), .CFG_BIT(cfg_bit[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
   );

   pal_cfg_loader #(.SR_LEN(192), .DATA_W(8)) u_dut192 (
      .CLK(CLK), .RES_N(RES_N), .START(start[1]), .ABORT(abort[1]),
      .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
      .CFG_EN(cfg_en[1]), .CFG_BIT(cfg_bit[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int           en_cnt[2];
   int           done_cnt[2];
   int           last_en[2];
   logic [191:0] chain[2];
   logic [191:0] exp_chain[2];
   bit           exp_q[$];
   logic [7:0]   tx_q[$];

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge CLK) cyc++;

   // Chain model and scoreboard: every CFG_EN cycle shifts one bit in and pops one expected bit.
   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (cfg_en[k]) begin
            en_cnt[k]++;
            last_en[k] = cyc;
            chain[k]   = {chain[k][190:0], cfg_bit[k]};
            if (exp_q.size() == 0) begin
               check_eq("unexpected_cfg_en_qsize", 192'(exp_q.size()), 192'(1));
            end else begin
               check_eq("cfg_bit", 192'(cfg_bit[k]), 192'(exp_q.pop_front()));
            end
         end
         if (done[k]) begin
            done_cnt[k]++;
`ifndef PAL_CFG_LOADER_CHECKSUM_EN
            check_eq("done_latency", 192'(cyc), 192'(last_en[k] + 1));
`endif
         end
      end
   end

   task automatic push_byte(input int k, input logic [7:0] b, input int idx);
      int n;
      n = ((k == 0) ? 12 : 192) - 8 * idx;
      if (n > 8) n = 8;
      for (int j = 0; j < n; j++) begin
         exp_q.push_back(b[7-j]);
         exp_chain[k] = {exp_chain[k][190:0], b[7-j]};
      end
   endtask

   // Called and returns at a negedge; returns in the first cycle after acceptance.
   task automatic send_byte(input int k, input logic [7:0] b);
      logic r;
      bit   ok;
      ok = 1'b0;
      in_valid[k] = 1'b1;
      in_data[k]  = b;
      for (int i = 0; i < 200; i++) begin
         r = in_ready[k];
         @(negedge CLK);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid[k] = 1'b0;
      check_eq("byte_accepted", 192'(ok), 192'(1));
   endtask

   task automatic do_start(input int k);
      start[k] = 1'b1;
      @(negedge CLK);
      start[k] = 1'b0;
      check_eq("start_busy", 192'(busy[k]), 192'(1));
      check_eq("start_in_ready", 192'(in_ready[k]), 192'(1));
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      check_eq("start_err_clear", 192'(err[k]), 192'(0));
`endif
   endtask

   // gap < 0 picks a random 0..3 cycle gap between bytes.
   task automatic run_load(input int k, input int gap, input bit gap_chk, input bit poke_start, input bit csum_ok);
      int         slen, e0, d0, g;
      logic [7:0] b, x;
      slen = (k == 0) ? 12 : 192;
      e0 = en_cnt[k];
      d0 = done_cnt[k];
      chain[k] = '0;
      exp_chain[k] = '0;
      x = 8'h00;
      do_start(k);
      for (int i = 0; i < tx_q.size(); i++) begin
         b = tx_q[i];
         push_byte(k, b, i);
         x = x ^ b;
         send_byte(k, b);
         if (i == 0 && poke_start) begin
            repeat (2) @(negedge CLK);
            start[k] = 1'b1;
            @(negedge CLK);
            start[k] = 1'b0;
         end
         if (i < tx_q.size() - 1) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            repeat (g) @(negedge CLK);
            if (gap_chk && i == 0) check_eq("en_during_gap", 192'(en_cnt[k] - e0), 192'(8));
         end
      end
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      send_byte(k, csum_ok ? x : (x ^ 8'h01));
`endif
      for (int i = 0; i < 60; i++) begin
         if (done_cnt[k] != d0) break;
         @(negedge CLK);
      end
      repeat (2) @(negedge CLK);
      check_eq("done_pulses", 192'(done_cnt[k] - d0), 192'(1));
      check_eq("cfg_en_cycles", 192'(en_cnt[k] - e0), 192'(slen));
      check_eq("busy_after", 192'(busy[k]), 192'(0));
      check_eq("chain", chain[k], exp_chain[k]);
      check_eq("queue_drained", 192'(exp_q.size()), 192'(0));
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      check_eq("err", 192'(err[k]), 192'(!csum_ok));
`else
      check_eq("err", 192'(err[k]), 192'(0));
`endif
   endtask

   task automatic check_idle_outputs(input int k, input string tag);
      check_eq({tag, "_in_ready"}, 192'(in_ready[k]), 192'(0));
      check_eq({tag, "_cfg_en"},   192'(cfg_en[k]),   192'(0));
      check_eq({tag, "_cfg_bit"},  192'(cfg_bit[k]),  192'(0));
      check_eq({tag, "_busy"},     192'(busy[k]),     192'(0));
      check_eq({tag, "_done"},     192'(done[k]),     192'(0));
      check_eq({tag, "_err"},      192'(err[k]),      192'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int e0, d0;
      RES_N = 1'b0;
      start = '0; abort = '0; in_valid = '0; in_data = '0;
      for (int k = 0; k < 2; k++) begin
         en_cnt[k] = 0; done_cnt[k] = 0; last_en[k] = 0; chain[k] = '0; exp_chain[k] = '0;
      end
      #12;
      check_idle_outputs(0, "reset12");
      check_idle_outputs(1, "reset192");
      @(negedge CLK);
      RES_N = 1'b1;
      @(negedge CLK);

      // Basic 12-bit load with a partial final byte.
      tx_q = '{8'hA5, 8'h3F};
      run_load(0, 0, 1'b0, 1'b0, 1'b1);

      // Gap between bytes: loader idles in LOAD with CFG_EN low.
      tx_q = '{8'hFF, 8'h0F};
      run_load(0, 13, 1'b1, 1'b0, 1'b1);

`ifdef PAL_CFG_LOADER_CHECKSUM_EN
      // Wrong checksum: ERR is sticky until the next START.
      tx_q = '{8'hA5, 8'h3F};
      run_load(0, 0, 1'b0, 1'b0, 1'b0);
      repeat (4) begin
         @(negedge CLK);
         check_eq("err_sticky", 192'(err[0]), 192'(1));
      end
      do_start(0);
      abort[0] = 1'b1;
      @(negedge CLK);
      abort[0] = 1'b0;
      @(negedge CLK);
`endif

      // Abort during the fifth shift of the first byte.
      e0 = en_cnt[0];
      d0 = done_cnt[0];
      do_start(0);
      push_byte(0, 8'hA5, 0);
      send_byte(0, 8'hA5);
      repeat (4) @(negedge CLK);
      abort[0] = 1'b1;
      @(negedge CLK);
      abort[0] = 1'b0;
      check_eq("abort_busy", 192'(busy[0]), 192'(0));
      check_eq("abort_cfg_en", 192'(cfg_en[0]), 192'(0));
      check_eq("abort_in_ready", 192'(in_ready[0]), 192'(0));
      exp_q.delete();
      repeat (20) @(negedge CLK);
      check_eq("abort_en_cycles", 192'(en_cnt[0] - e0), 192'(5));
      check_eq("abort_no_done", 192'(done_cnt[0] - d0), 192'(0));

      // Full load after abort.
      tx_q = '{8'h5A, 8'hC3};
      run_load(0, 0, 1'b0, 1'b0, 1'b1);

      // START pulsed during SHIFT has no effect.
      tx_q = '{8'h96, 8'hE1};
      run_load(0, 0, 1'b0, 1'b1, 1'b1);

      // Asynchronous reset in the middle of a shift.
      do_start(0);
      push_byte(0, 8'h3C, 0);
      send_byte(0, 8'h3C);
      repeat (2) @(negedge CLK);
      #2 RES_N = 1'b0;
      #1 check_idle_outputs(0, "async_reset");
      @(negedge CLK);
      RES_N = 1'b1;
      exp_q.delete();
      @(negedge CLK);

      tx_q = '{8'hA5, 8'h3F};
      run_load(0, 1, 1'b0, 1'b0, 1'b1);

      // Full-length 192-bit chain with random bytes and random gaps.
      tx_q.delete();
      for (int i = 0; i < 24; i++) tx_q.push_back(8'($urandom_range(255, 0)));
      run_load(1, -1, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
